// File: rtl/image_frame_buffer.sv
// Raster pixel-stream frame buffer: auto-addressed capture into block RAM plus an independent read port.
// Define IMAGE_FRAME_BUFFER_DOUBLE_EN for ping-pong double buffering with a hold-gated bank swap.
module image_frame_buffer #(
    parameter int DATA_W = 24,
    parameter int IMG_W  = 128,
    parameter int IMG_H  = 128,
    parameter int DEPTH  = IMG_W * IMG_H,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_wr_valid,
    input  logic              i_wr_sof,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    input  logic              i_rd_hold,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_rd_valid,
    output logic              o_frame_done,
    output logic              o_drop,
    output logic              o_wr_busy,
    output logic              o_rd_bank
);
`ifdef IMAGE_FRAME_BUFFER_DOUBLE_EN
    localparam int NBANK = 2;
`else
    localparam int NBANK = 1;
`endif
    localparam int                MEM_WORDS = NBANK * DEPTH;
    localparam int                MEM_AW    = $clog2(MEM_WORDS);
    localparam logic [ADDR_W-1:0] LAST      = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   LIMIT     = (ADDR_W + 1)'(DEPTH);
    localparam logic [MEM_AW-1:0] BANK_OFS  = MEM_AW'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_DONE} state_t;

    state_t            state;
    logic [ADDR_W-1:0] wr_cnt;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_en;
    logic              wr_sel;
    logic              rd_sel;
    logic              rd_in_range;
    logic [MEM_AW-1:0] wr_idx;
    logic [MEM_AW-1:0] rd_idx;
    logic [DATA_W-1:0] mem [MEM_WORDS];

`ifdef IMAGE_FRAME_BUFFER_DOUBLE_EN
    logic wr_bank;
    logic rd_bank;
    assign wr_sel = wr_bank;
    assign rd_sel = rd_bank;
`else
    logic unused_hold;
    assign wr_sel      = 1'b0;
    assign rd_sel      = 1'b0;
    assign unused_hold = i_rd_hold;
`endif

    // An sof beat always lands at address 0, whether it starts or restarts a frame.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = wr_cnt;
        if (i_wr_valid && state != S_DONE) begin
            if (i_wr_sof) begin
                wr_en   = 1'b1;
                wr_addr = '0;
            end else if (state == S_FILL) begin
                wr_en = 1'b1;
            end
        end
    end

    assign wr_idx      = MEM_AW'(wr_addr) + (wr_sel ? BANK_OFS : '0);
    assign rd_idx      = MEM_AW'(i_rd_addr) + (rd_sel ? BANK_OFS : '0);
    assign rd_in_range = {1'b0, i_rd_addr} < LIMIT;
    assign o_rd_bank   = rd_sel;

    always_ff @(posedge i_clk) begin
        if (wr_en) mem[wr_idx] <= i_wr_data;
    end

    // Non-blocking read of mem gives old data on a same-cycle same-address write.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_rd_data  <= '0;
            o_rd_valid <= 1'b0;
        end else begin
            o_rd_valid <= i_rd_en;
            if (i_rd_en) o_rd_data <= rd_in_range ? mem[rd_idx] : '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= S_IDLE;
            wr_cnt       <= '0;
            o_frame_done <= 1'b0;
            o_drop       <= 1'b0;
            o_wr_busy    <= 1'b0;
`ifdef IMAGE_FRAME_BUFFER_DOUBLE_EN
            wr_bank      <= 1'b1;
            rd_bank      <= 1'b0;
`endif
        end else begin
            o_frame_done <= 1'b0;
            o_drop       <= 1'b0;
            case (state)
                S_IDLE, S_FILL: begin
                    if (i_wr_valid && i_wr_sof) begin
                        wr_cnt    <= ADDR_W'(1);
                        state     <= S_FILL;
                        o_wr_busy <= 1'b1;
                    end else if (i_wr_valid && state == S_FILL) begin
                        if (wr_cnt == LAST) begin
                            wr_cnt       <= '0;
                            state        <= S_DONE;
                            o_frame_done <= 1'b1;
                            o_wr_busy    <= 1'b0;
                        end else begin
                            wr_cnt <= wr_cnt + ADDR_W'(1);
                        end
                    end
                end
                S_DONE: begin
`ifdef IMAGE_FRAME_BUFFER_DOUBLE_EN
                    // Completed bank waits here until the reader releases the current one.
                    if (i_wr_valid && i_wr_sof) o_drop <= 1'b1;
                    if (!i_rd_hold) begin
                        rd_bank <= wr_bank;
                        wr_bank <= rd_bank;
                        state   <= S_IDLE;
                    end
`else
                    state <= S_IDLE;
`endif
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_image_frame_buffer.sv
// Directed bench for image_frame_buffer: per-cycle compare against a frame-level model plus literal checks.
module tb_image_frame_buffer;
`ifdef IMAGE_FRAME_BUFFER_DOUBLE_EN
    localparam bit DBL = 1'b1;
`else
    localparam bit DBL = 1'b0;
`endif
    localparam int M_DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wv = 1'b0, ws = 1'b0, re = 1'b0, hold = 1'b0;
    logic [23:0] wd = '0;
    logic [3:0]  ra = '0;
    logic [23:0] rd_data;
    logic        rd_valid, frame_done, drop, wr_busy, rd_bank;

    logic        w2v = 1'b0, w2s = 1'b0, r2e = 1'b0;
    logic [23:0] w2d = '0;
    logic [3:0]  r2a = '0;
    logic [23:0] rd2_data;
    logic        rd2_valid, frame2_done, drop2, wr2_busy, rd2_bank;

    int n_cmp = 0, n_bad = 0, done_cnt = 0;

    image_frame_buffer #(.DATA_W(24), .IMG_W(4), .IMG_H(4)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_wr_valid(wv), .i_wr_sof(ws), .i_wr_data(wd),
        .i_rd_en(re), .i_rd_addr(ra), .i_rd_hold(hold), .o_rd_data(rd_data), .o_rd_valid(rd_valid),
        .o_frame_done(frame_done), .o_drop(drop), .o_wr_busy(wr_busy), .o_rd_bank(rd_bank));

    image_frame_buffer #(.DATA_W(24), .IMG_W(3), .IMG_H(5)) dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_wr_valid(w2v), .i_wr_sof(w2s), .i_wr_data(w2d),
        .i_rd_en(r2e), .i_rd_addr(r2a), .i_rd_hold(1'b0), .o_rd_data(rd2_data), .o_rd_valid(rd2_valid),
        .o_frame_done(frame2_done), .o_drop(drop2), .o_wr_busy(wr2_busy), .o_rd_bank(rd2_bank));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: two frame arrays, a fill index and a pending-swap flag.
    logic [23:0] mmem [2][M_DEPTH];
    bit          mknown [2][M_DEPTH];
    bit          m_fill = 0, m_pend = 0, m_wb = DBL, m_rb = 0;
    int          m_cnt = 0;
    bit          e_done = 0, e_drop = 0, e_busy = 0, e_rv = 0, e_known = 1;
    logic [23:0] e_rd = '0;

    task automatic model_step();
        int idx;
        if (!rst_n) begin
            m_fill = 0; m_pend = 0; m_cnt = 0; m_wb = DBL; m_rb = 0;
            e_done = 0; e_drop = 0; e_busy = 0; e_rv = 0; e_rd = '0; e_known = 1;
            return;
        end
        e_rv = re;
        if (re) begin
            if (int'(ra) >= M_DEPTH) begin
                e_rd = '0; e_known = 1;
            end else begin
                e_rd = mmem[m_rb][ra]; e_known = mknown[m_rb][ra];
            end
        end
        e_done = 0; e_drop = 0;
        if (m_pend) begin
            if (!DBL) m_pend = 0;
            else begin
                if (wv && ws) e_drop = 1;
                if (!hold) begin
                    m_rb = m_wb; m_wb = ~m_wb; m_pend = 0;
                end
            end
        end else if (wv && (ws || m_fill)) begin
            idx = ws ? 0 : m_cnt;
            mmem[m_wb][idx] = wd;
            mknown[m_wb][idx] = 1;
            if (idx == M_DEPTH - 1) begin
                m_fill = 0; m_cnt = 0; m_pend = 1; e_done = 1;
            end else begin
                m_fill = 1; m_cnt = idx + 1;
            end
        end
        e_busy = m_fill;
    endtask

    always @(posedge clk or negedge rst_n) model_step();

    always @(negedge clk) begin
        if (frame_done) done_cnt++;
        chk("rd_valid", rd_valid, e_rv);
        chk("frame_done", frame_done, e_done);
        chk("drop", drop, e_drop);
        chk("wr_busy", wr_busy, e_busy);
        chk("rd_bank", rd_bank, m_rb);
        if (e_known) chk("rd_data", rd_data, e_rd);
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic beat(input bit sof, input logic [23:0] d);
        wv = 1; ws = sof; wd = d;
        tick();
        wv = 0; ws = 0;
    endtask

    task automatic rd_chk(input logic [3:0] a, input logic [23:0] exp);
        re = 1; ra = a;
        tick();
        re = 0;
        chk("lit_rd_valid", rd_valid, 1);
        chk("lit_rd_data", rd_data, exp);
    endtask

    initial begin
        #200000;
        n_bad++;
        $display("FAIL watchdog: run did not finish, expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rd_data", rd_data, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_busy", wr_busy, 0);
        chk("rst_bank", rd_bank, 0);
        rst_n = 1;
        tick();

        // Full frame, data = index
        for (int i = 0; i < 16; i++) beat(i == 0, 24'(i));
        chk("done_after_last", frame_done, 1);
        tick(); tick();
        chk("done_once", done_cnt, 1);
        for (int a = 0; a < 16; a++) rd_chk(4'(a), 24'(a));
        tick();
        chk("rd_valid_drop", rd_valid, 0);
        chk("rd_data_hold", rd_data, 15);

        // Beats without sof are ignored
        for (int i = 0; i < 5; i++) beat(0, 24'h55);
        chk("nosof_busy", wr_busy, 0);
        chk("nosof_done", done_cnt, 1);
        rd_chk(4'd0, 24'd0);

        // Restart mid-frame
        for (int i = 0; i < 7; i++) begin
            beat(i == 0, 24'h80 + 24'(i));
            if (i == 0) chk("busy_after_sof", wr_busy, 1);
        end
        for (int i = 0; i < 16; i++) beat(i == 0, 24'h100 + 24'(i));
        tick(); tick();
        chk("restart_done_once", done_cnt, 2);
        for (int a = 0; a < 16; a++) rd_chk(4'(a), 24'h100 + 24'(a));

`ifdef IMAGE_FRAME_BUFFER_DOUBLE_EN
        // Held reader: swap deferred, sof dropped, old frame still served
        hold = 1;
        for (int i = 0; i < 16; i++) beat(i == 0, 24'h200 + 24'(i));
        tick(); tick();
        chk("hold_bank", rd_bank, 0);
        beat(1, 24'h999);
        chk("drop_pulse", drop, 1);
        rd_chk(4'd3, 24'h103);
        hold = 0;
        tick();
        chk("swap_bank", rd_bank, 1);
        for (int a = 0; a < 16; a++) rd_chk(4'(a), 24'h200 + 24'(a));
`endif

        // Out-of-range read on a 3x5 (DEPTH=15) instance
        for (int i = 0; i < 15; i++) begin
            w2v = 1; w2s = (i == 0); w2d = 24'hA00 + 24'(i);
            tick();
        end
        w2v = 0; w2s = 0;
        chk("d2_done", frame2_done, 1);
        tick(); tick();
        r2e = 1; r2a = 4'd14;
        tick();
        chk("d2_rd14_valid", rd2_valid, 1);
        chk("d2_rd14_data", rd2_data, 24'hA0E);
        r2a = 4'd15;
        tick();
        r2e = 0;
        chk("d2_rd15_valid", rd2_valid, 1);
        chk("d2_rd15_data", rd2_data, 0);
        chk("d2_drop", drop2, 0);

        // Reset at beat 9, then a clean frame
        for (int i = 0; i < 9; i++) beat(i == 0, 24'h300 + 24'(i));
        wv = 1; wd = 24'h309; rst_n = 0;
        #2;
        chk("mid_rst_rd_data", rd_data, 0);
        chk("mid_rst_valid", rd_valid, 0);
        chk("mid_rst_done", frame_done, 0);
        chk("mid_rst_drop", drop, 0);
        chk("mid_rst_busy", wr_busy, 0);
        chk("mid_rst_bank", rd_bank, 0);
        tick();
        wv = 0; rst_n = 1;
        tick();
        for (int i = 0; i < 16; i++) beat(i == 0, 24'h400 + 24'(i));
        chk("post_rst_done", frame_done, 1);
        tick(); tick();
        for (int a = 0; a < 16; a++) rd_chk(4'(a), 24'h400 + 24'(a));
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
